// File: rtl/bk_wide_add_seq_pkg.sv
// Shared constants and state encoding for the sequential wide adder.
// Optional subtract support is selected by the BK_SUB_EN macro in the users of this package.
package bk_pkg;

  localparam int BK_LANE_W     = 32;
  localparam int BK_MAX_NWORDS = 8;

  typedef enum logic [1:0] {
    BK_ST_IDLE = 2'd0,
    BK_ST_RUN  = 2'd1,
    BK_ST_DONE = 2'd2
  } bk_state_e;

  // Lane counter width; a single-lane build still keeps a 1-bit counter.
  function automatic int bk_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bk_wide_add_seq_if.sv
// Operand/result handshake bundle for bk_wide_add_seq.
// in_sub exists only when BK_SUB_EN is defined.
interface bk_wide_add_seq_if #(
  parameter int NWORDS = 4
) ();

  logic                                  in_valid;
  logic                                  in_ready;
  logic [bk_pkg::BK_LANE_W*NWORDS-1:0]   in_a;
  logic [bk_pkg::BK_LANE_W*NWORDS-1:0]   in_b;
  logic                                  in_cin;
`ifdef BK_SUB_EN
  logic                                  in_sub;
`endif
  logic                                  out_valid;
  logic                                  out_ready;
  logic [bk_pkg::BK_LANE_W*NWORDS-1:0]   out_sum;
  logic                                  out_cout;
  logic                                  busy;

  modport slave (
`ifdef BK_SUB_EN
    input  in_sub,
`endif
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
  );

  modport master (
`ifdef BK_SUB_EN
    output in_sub,
`endif
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy
  );

endinterface

// File: rtl/bk_wide_add_seq_brent_kung32.sv
// 32-bit Brent-Kung parallel-prefix adder (combinational), shared by the lane sequencer.
module brent_kung32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] w_p0;
  logic [31:0] w_g;
  logic [31:0] w_p;

  assign w_p0 = a ^ b;

  always_comb begin
    w_g    = a & b;
    w_p    = w_p0;
    // Fold the carry-in into bit 0 so every group generate is a true carry.
    w_g[0] = w_g[0] | (w_p0[0] & cin);
    for (int l = 0; l < 5; l++) begin
      for (int i = (2 << l) - 1; i < 32; i += (2 << l)) begin
        w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
        w_p[i] = w_p[i] & w_p[i - (1 << l)];
      end
    end
    for (int l = 3; l >= 0; l--) begin
      for (int i = 3 * (1 << l) - 1; i < 32; i += (2 << l)) begin
        w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
        w_p[i] = w_p[i] & w_p[i - (1 << l)];
      end
    end
  end

  assign sum  = w_p0 ^ {w_g[30:0], cin};
  assign cout = w_g[31];

endmodule

// File: rtl/bk_wide_add_seq.sv
// Wide adder that time-shares one brent_kung32 across NWORDS lanes, LSB lane first.
// Define BK_SUB_EN to add the in_sub (A - B) mode.
module bk_wide_add_seq
  import bk_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic           clk,
  input  logic           rst,
  bk_wide_add_seq_if.slave bus
);

  localparam int CNT_W = bk_cnt_w(NWORDS);
  localparam int W     = BK_LANE_W * NWORDS;

  bk_state_e              r_state;
  bk_state_e              w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_carry;
  logic [W-1:0]           r_a;
  logic [W-1:0]           r_b;
  logic [W-1:0]           r_sum;
  logic                   r_cout;
`ifdef BK_SUB_EN
  logic                   r_sub;
`endif

  logic                   w_in_ready;
  logic                   w_out_valid;
  logic                   w_busy;
  logic                   w_last;
  logic [BK_LANE_W-1:0]   w_a_lane;
  logic [BK_LANE_W-1:0]   w_b_lane;
  logic [BK_LANE_W-1:0]   w_b_adder;
  logic [BK_LANE_W-1:0]   w_lane_sum;
  logic                   w_lane_cout;

  always_comb begin
    w_a_lane = '0;
    w_b_lane = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_a_lane = r_a[i*BK_LANE_W +: BK_LANE_W];
        w_b_lane = r_b[i*BK_LANE_W +: BK_LANE_W];
      end
    end
  end

`ifdef BK_SUB_EN
  assign w_b_adder = r_sub ? ~w_b_lane : w_b_lane;
`else
  assign w_b_adder = w_b_lane;
`endif

  brent_kung32 u_add (
    .a   (w_a_lane),
    .b   (w_b_adder),
    .cin (r_carry),
    .sum (w_lane_sum),
    .cout(w_lane_cout)
  );

  assign w_last = (r_cnt == CNT_W'(NWORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= BK_ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      BK_ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = BK_ST_RUN;
      end
      BK_ST_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_next = BK_ST_DONE;
      end
      BK_ST_DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = BK_ST_IDLE;
      end
      default: w_next = BK_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef BK_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      case (r_state)
        BK_ST_IDLE: begin
          if (bus.in_valid && w_in_ready) begin
            r_a   <= bus.in_a;
            r_b   <= bus.in_b;
            r_cnt <= '0;
`ifdef BK_SUB_EN
            // Two's-complement subtract: invert B lanes and inject a carry of one.
            r_sub   <= bus.in_sub;
            r_carry <= bus.in_sub ? 1'b1 : bus.in_cin;
`else
            r_carry <= bus.in_cin;
`endif
          end
        end
        BK_ST_RUN: begin
          for (int i = 0; i < NWORDS; i++) begin
            if (r_cnt == CNT_W'(i)) r_sum[i*BK_LANE_W +: BK_LANE_W] <= w_lane_sum;
          end
          r_carry <= w_lane_cout;
          if (w_last) r_cout <= w_lane_cout;
          else        r_cnt  <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_cout;

endmodule

// File: tb/tb_bk_wide_add_seq.sv
// Scoreboard bench for bk_wide_add_seq: a 4-lane and a 1-lane instance.
// Subtract cases are exercised when BK_SUB_EN is defined.
module tb_bk_wide_add_seq;
  import bk_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bk_wide_add_seq_if #(.NWORDS(4)) bus4 ();
  bk_wide_add_seq_if #(.NWORDS(1)) bus1 ();

  bk_wide_add_seq #(.NWORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  bk_wide_add_seq #(.NWORDS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int n_chk = 0;
  int n_err = 0;

  logic [128:0] q4[$];
  logic [32:0]  q1[$];

  task automatic check_val(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [128:0] exp_add4(input logic [127:0] a, input logic [127:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {128'd0, c};
  endfunction

  function automatic logic [128:0] exp_sub4(input logic [127:0] a, input logic [127:0] b);
    return {1'b0, a} + {1'b0, ~b} + 129'd1;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus4.out_valid && bus4.out_ready) begin
      check_val("sb4_pending", 160'(q4.size()), 160'(1));
      if (q4.size() > 0) check_val("sb4_result", 160'({bus4.out_cout, bus4.out_sum}), 160'(q4.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && bus1.out_valid && bus1.out_ready) begin
      check_val("sb1_pending", 160'(q1.size()), 160'(1));
      if (q1.size() > 0) check_val("sb1_result", 160'({bus1.out_cout, bus1.out_sum}), 160'(q1.pop_front()));
    end
  end

  task automatic run4(input logic [127:0] a, input logic [127:0] b, input logic cin,
                      input logic [128:0] e, input int hold);
    int lat;
    logic [127:0] held;
    @(posedge clk); #1;
    bus4.in_a     = a;
    bus4.in_b     = b;
    bus4.in_cin   = cin;
    bus4.in_valid = 1'b1;
    if (hold > 0) bus4.out_ready = 1'b0;
    q4.push_back(e);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    bus4.in_a     = {$urandom, $urandom, $urandom, $urandom};
    bus4.in_b     = {$urandom, $urandom, $urandom, $urandom};
    bus4.in_cin   = 1'b1;
    lat = 0;
    while (!bus4.out_valid && lat < 20) begin
      check_val("in_ready_run", 160'(bus4.in_ready), 160'(0));
      @(posedge clk); #1;
      lat++;
    end
    check_val("latency4", 160'(lat), 160'(4));
    check_val("in_ready_done", 160'(bus4.in_ready), 160'(0));
    held = bus4.out_sum;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_val("bp_valid", 160'(bus4.out_valid), 160'(1));
      check_val("bp_sum", 160'(bus4.out_sum), 160'(held));
      check_val("bp_in_ready", 160'(bus4.in_ready), 160'(0));
    end
    if (hold > 0) bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("idle_in_ready", 160'(bus4.in_ready), 160'(1));
    check_val("idle_valid", 160'(bus4.out_valid), 160'(0));
  endtask

  task automatic run1(input logic [31:0] a, input logic [31:0] b, input logic cin);
    int lat;
    @(posedge clk); #1;
    bus1.in_a     = a;
    bus1.in_b     = b;
    bus1.in_cin   = cin;
    bus1.in_valid = 1'b1;
    q1.push_back({1'b0, a} + {1'b0, b} + {32'd0, cin});
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    bus1.in_a     = $urandom;
    bus1.in_b     = $urandom;
    lat = 0;
    while (!bus1.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("latency1", 160'(lat), 160'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] ra, rb;
    #400000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] ra, rb;
    logic         rc;
    rst = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_cin = 1'b0; bus4.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0; bus1.out_ready = 1'b1;
`ifdef BK_SUB_EN
    bus4.in_sub = 1'b0;
    bus1.in_sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", 160'(bus4.out_valid), 160'(0));
    check_val("rst_sum", 160'(bus4.out_sum), 160'(0));
    check_val("rst_cout", 160'(bus4.out_cout), 160'(0));
    check_val("rst_busy", 160'(bus4.busy), 160'(0));
    @(negedge clk); rst = 1'b0;
    #1;
    check_val("rst_in_ready", 160'(bus4.in_ready), 160'(1));

    run4({128{1'b1}}, 128'd1, 1'b0, exp_add4({128{1'b1}}, 128'd1, 1'b0), 0);
    run4(128'd1024, 128'd1023, 1'b0, exp_add4(128'd1024, 128'd1023, 1'b0), 0);

    ra = {$urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
    run4(ra, rb, 1'b1, exp_add4(ra, rb, 1'b1), 5);

    // Abort a transaction at lane 2 with an asynchronous reset.
    @(posedge clk); #1;
    bus4.in_a = {4{32'hDEADBEEF}}; bus4.in_b = {4{32'h12345678}}; bus4.in_cin = 1'b0;
    bus4.in_valid = 1'b1;
    q4.push_back(exp_add4({4{32'hDEADBEEF}}, {4{32'h12345678}}, 1'b0));
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check_val("mid_busy_before", 160'(bus4.busy), 160'(1));
    rst = 1'b1;
    #1;
    check_val("mid_rst_valid", 160'(bus4.out_valid), 160'(0));
    check_val("mid_rst_sum", 160'(bus4.out_sum), 160'(0));
    check_val("mid_rst_busy", 160'(bus4.busy), 160'(0));
    void'(q4.pop_back());
    @(negedge clk); rst = 1'b0;

    run4({4{32'h89ABCDEF}}, {4{32'h76543210}}, 1'b1,
         exp_add4({4{32'h89ABCDEF}}, {4{32'h76543210}}, 1'b1), 0);
    for (int t = 0; t < 4; t++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      run4(ra, rb, rc, exp_add4(ra, rb, rc), 0);
    end

`ifdef BK_SUB_EN
    bus4.in_sub = 1'b1;
    run4(128'd5, 128'd7, 1'b0, exp_sub4(128'd5, 128'd7), 0);
    run4(128'd7, 128'd5, 1'b1, exp_sub4(128'd7, 128'd5), 0);
    bus4.in_sub = 1'b0;
`endif

    for (int t = 0; t < 30; t++) begin
      run1(32'($urandom_range(0, 32767)), 32'($urandom_range(0, 32767)), 1'($urandom_range(0, 1)));
    end
    run1(32'hFFFFFFFF, 32'd1, 1'b0);
    run1(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check_val("sb4_drain", 160'(q4.size()), 160'(0));
    check_val("sb1_drain", 160'(q1.size()), 160'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
